// File: rtl/ws2812_rx_if.sv
// WS2812 receiver line and decode bundle.
// master drives the decoded outputs; slave is the consumer side.
interface ws2812_rx_if;
    logic        din;
    logic        dout;
    logic [23:0] color;
    logic        color_valid;
    logic        frame_done;
    logic        err;

    modport master (
        input  din,
        output dout,
        output color,
        output color_valid,
        output frame_done,
        output err
    );

    modport slave (
        output din,
        input  dout,
        input  color,
        input  color_valid,
        input  frame_done,
        input  err
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 one-wire receiver: decodes the first GRB word of a frame
// and forwards the rest of the frame on dout like a chained LED.
module ws2812_rx #(
    parameter int T_MIN    = 5,
    parameter int T_THRESH = 29,
    parameter int T_MAX    = 96,
    parameter int T_RESET  = 2400,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    ws2812_rx_if.master bus
);
    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(T_MIN);
    localparam logic [CNT_W-1:0] C_THR  = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(T_MAX);
    localparam logic [CNT_W-1:0] C_RST  = CNT_W'(T_RESET);
    localparam logic [CNT_W-1:0] C_RST1 = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           state;
    logic             s1, s, s_d;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_cnt;
    logic [23:0]      shreg;
    logic             fwd;
    logic [23:0]      color_q;
    logic             dout_q, valid_q, done_q, err_q;
    logic             rise;

    assign rise = s & ~s_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= SYNC;
            s1      <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            fwd     <= 1'b0;
            color_q <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1      <= bus.din;
            s       <= s1;
            s_d     <= s;
            dout_q  <= fwd & s;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;

            // word completes one cycle after its last bit is shifted in
            if (bit_cnt == 5'd24) begin
                color_q <= shreg;
                valid_q <= 1'b1;
                fwd     <= 1'b1;
                bit_cnt <= '0;
            end

            unique case (state)
                SYNC: begin
                    if (s) begin
                        cnt <= '0;
                    end else if (cnt >= C_RST1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= C_ONE;
                    end
                end
                HIGH: begin
                    if (s) begin
                        if (cnt >= C_MAX) begin
                            err_q   <= 1'b1;
                            bit_cnt <= '0;
                            fwd     <= 1'b0;
                            cnt     <= '0;
                            state   <= SYNC;
                        end else begin
                            cnt <= cnt + C_ONE;
                        end
                    end else begin
                        state <= LOW;
                        cnt   <= C_ONE;
                        if (cnt >= C_MIN && !fwd) begin
                            shreg   <= {shreg[22:0], (cnt >= C_THR)};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= C_ONE;
                    end else if (cnt >= C_RST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        done_q  <= (bit_cnt != 5'd0) || fwd;
                        err_q   <= (bit_cnt != 5'd0);
                        bit_cnt <= '0;
                        fwd     <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + C_ONE;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    assign bus.dout        = dout_q;
    assign bus.color       = color_q;
    assign bus.color_valid = valid_q;
    assign bus.frame_done  = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: frame-level model of decode, forwarding and
// latch-gap events, with directed boundary frames and random frames.
module tb_ws2812_rx;
    localparam int T_MIN    = 5;
    localparam int T_THRESH = 29;
    localparam int T_MAX    = 96;
    localparam int T_RESET  = 2400;
    localparam int GAP      = 2450;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ws2812_rx_if bus();

    ws2812_rx #(
        .T_MIN(T_MIN), .T_THRESH(T_THRESH), .T_MAX(T_MAX),
        .T_RESET(T_RESET), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_fd = 0, n_err = 0, n_errfd = 0, n_rise = 0;
    logic [23:0] last_col = '0;
    logic [23:0] exp_color = '0;
    logic synced = 1'b0;
    logic mon_on = 1'b0;
    logic fwd_pulse = 1'b0;
    logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
    logic dout_prev = 1'b0;
    int wq[$];
    int lq[$];

    // a forwarded line is din delayed by three flops
    always @(posedge clk) begin
        d1 <= bus.din & fwd_pulse;
        d2 <= d1;
        d3 <= d2;
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                checks++;
                if (bus.dout !== d3) begin
                    errors++;
                    $display("FAIL dout @%0t: got %b expected %b",
                             $time, bus.dout, d3);
                end
                checks++;
                if (bus.color_valid === 1'b1 && bus.frame_done === 1'b1) begin
                    errors++;
                    $display("FAIL valid_done_overlap @%0t: got 1 expected 0",
                             $time);
                end
                if (bus.color_valid) begin
                    n_valid++;
                    last_col = bus.color;
                end
                if (bus.frame_done) n_fd++;
                if (bus.err) n_err++;
                if (bus.err && bus.frame_done) n_errfd++;
                if (bus.dout && !dout_prev) n_rise++;
                dout_prev = bus.dout;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int w, input int l, input logic f);
        bus.din = 1'b1;
        fwd_pulse = f;
        repeat (w) @(negedge clk);
        bus.din = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic add(input int w, input int l);
        wq.push_back(w);
        lq.push_back(l);
    endtask

    task automatic add_word(input logic [23:0] v);
        for (int i = 23; i >= 0; i--) begin
            int w;
            w = v[i] ? 38 : 19;
            add(w, 60 - w);
        end
    endtask

    task automatic idle(input int n);
        fwd_pulse = 1'b0;
        bus.din = 1'b0;
        repeat (n) @(negedge clk);
        if (n >= T_RESET) synced = 1'b1;
    endtask

    task automatic run_frame(input string name, input int gap);
        int nb, e_valid, e_fd, e_err, e_ef;
        int b_valid, b_fd, b_err, b_ef;
        logic [23:0] val, e_col;
        logic ab;
        nb = 0; e_valid = 0; e_fd = 0; e_err = 0; e_ef = 0;
        val = '0; ab = 1'b0; e_col = exp_color;
        b_valid = n_valid; b_fd = n_fd; b_err = n_err; b_ef = n_errfd;
        foreach (wq[i]) begin
            logic live;
            live = synced && !ab;
            pulse(wq[i], lq[i], live && nb >= 24);
            if (live) begin
                if (wq[i] > T_MAX) begin
                    e_err++;
                    ab = 1'b1;
                    synced = 1'b0;
                end else if (wq[i] >= T_MIN) begin
                    if (nb < 24) begin
                        val = {val[22:0], (wq[i] >= T_THRESH)};
                        if (nb == 23) begin
                            e_valid++;
                            e_col = val;
                        end
                    end
                    nb++;
                end
            end
        end
        fwd_pulse = 1'b0;
        bus.din = 1'b0;
        repeat (gap) @(negedge clk);
        if (gap >= T_RESET) begin
            if (synced && nb > 0) begin
                e_fd++;
                if (nb < 24) begin
                    e_err++;
                    e_ef++;
                end
            end
            synced = 1'b1;
        end
        chk({name, "_valid"}, n_valid - b_valid, e_valid);
        chk({name, "_done"}, n_fd - b_fd, e_fd);
        chk({name, "_err"}, n_err - b_err, e_err);
        chk({name, "_errdone"}, n_errfd - b_ef, e_ef);
        chk({name, "_color"}, bus.color, e_col);
        if (e_valid > 0) chk({name, "_vcolor"}, last_col, e_col);
        exp_color = e_col;
        wq.delete();
        lq.delete();
    endtask

    initial begin
        int b_rise, b_valid, b_fd;
        bus.din = 1'b0;
        repeat (5) @(negedge clk);
        mon_on = 1'b1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_color", bus.color, 0);
        chk("rst_valid", bus.color_valid, 0);
        chk("rst_done", bus.frame_done, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b1;

        add_word(24'hA5A5A5);
        run_frame("post_reset", GAP);
        chk("post_reset_lit", bus.color, 24'h000000);

        b_rise = n_rise;
        add_word(24'h12AB34);
        run_frame("f12ab34", GAP);
        chk("f12ab34_lit", bus.color, 24'h12AB34);
        chk("f12ab34_dout", n_rise - b_rise, 0);

        b_rise = n_rise;
        add_word(24'hFF0000);
        add_word(24'h00FF00);
        run_frame("fwd48", GAP);
        chk("fwd48_lit", bus.color, 24'hFF0000);
        chk("fwd48_pulses", n_rise - b_rise, 24);

        add(28, 32);
        add(4, 56);
        add(29, 31);
        for (int i = 0; i < 22; i++) add(19, 41);
        run_frame("thresh", GAP);
        chk("thresh_lit", bus.color, 24'h400000);

        add(96, 20);
        add(5, 30);
        for (int i = 0; i < 22; i++) add(19, 41);
        run_frame("minmax", GAP);
        chk("minmax_lit", bus.color, 24'h800000);

        for (int i = 0; i < 3; i++) add(19, 41);
        add(97, 20);
        run_frame("err97", 1000);
        add_word(24'hC3C3C3);
        run_frame("short_gap", GAP);
        chk("short_gap_lit", bus.color, 24'h800000);
        add_word(24'h0F1E2D);
        run_frame("resync", GAP);
        chk("resync_lit", bus.color, 24'h0F1E2D);

        for (int i = 0; i < 10; i++) add(38, 22);
        run_frame("partial", GAP);
        chk("partial_lit", bus.color, 24'h0F1E2D);

        for (int i = 0; i < 12; i++) pulse(38, 22, 1'b0);
        b_valid = n_valid;
        b_fd = n_fd;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_dout", bus.dout, 0);
        chk("mid_rst_color", bus.color, 0);
        chk("mid_rst_valid", bus.color_valid, 0);
        chk("mid_rst_done", bus.frame_done, 0);
        chk("mid_rst_err", bus.err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        synced = 1'b0;
        exp_color = '0;
        idle(2600);
        chk("mid_rst_nvalid", n_valid - b_valid, 0);
        chk("mid_rst_ndone", n_fd - b_fd, 0);
        add_word(24'h5A3C96);
        run_frame("after_rst", GAP);
        chk("after_rst_lit", bus.color, 24'h5A3C96);

        for (int f = 0; f < 6; f++) begin
            int kind, n;
            kind = $urandom_range(0, 3);
            n = (kind == 2) ? $urandom_range(1, 23) :
                (kind == 1) ? $urandom_range(25, 34) : 24;
            for (int i = 0; i < n; i++) begin
                int w;
                if ($urandom_range(0, 7) == 0)
                    add($urandom_range(1, T_MIN - 1), $urandom_range(6, 30));
                if ($urandom_range(0, 1) == 1)
                    w = $urandom_range(T_THRESH, T_MAX);
                else
                    w = $urandom_range(T_MIN, T_THRESH - 1);
                add(w, $urandom_range(6, 30));
            end
            run_frame($sformatf("rnd%0d", f), GAP);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

WS2812 one-wire receiver and daisy-chain repeater: the far-end counterpart of our WS2812 transmit path on `P6`. It oversamples the serial line, classifies each high pulse as a 0 or 1 bit by width, and assembles the first 24 bits of each frame into a GRB color word. All later bits in the frame pass through unchanged on `dout`, the same way a physical WS2812 passes data to the next LED. It sits behind a pin input and feeds the LED/PWM logic or a loopback checker for the transmitter.

## Interface
Parameters (all counts in `clk` cycles; defaults assume 48 MHz HFOSC):
- `T_MIN`, 5: high pulses shorter than this are glitches and are ignored.
- `T_THRESH`, 29: a high pulse of at least this width decodes as 1; shorter decodes as 0.
- `T_MAX`, 96: a high pulse longer than this is a framing error.
- `T_RESET`, 2400: a continuous low of this length ends the frame (latch).
- `CNT_W`, 16: width of the pulse counter. It must hold `T_RESET`.

Ports:
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `din`, input, 1: asynchronous serial line.
- `dout`, output, 1: forwarded stream.
- `color`, output, 24: last decoded word, in GRB order. G is bits 23:16 and bit 23 is the first bit received.
- `color_valid`, output, 1: one-cycle pulse when `color` updates.
- `frame_done`, output, 1: one-cycle pulse at the latch gap, only if at least one bit arrived.
- `err`, output, 1: one-cycle pulse on a framing error.

## Operation
- `din` passes through a 2-flop synchronizer, giving `s`. A third flop holds `s_d` for edge detection.
- State machine:
  - SYNC (after reset): count `s` low. When `T_RESET` is reached, go to IDLE. A high `s` clears the count. Bits are never decoded in SYNC.
  - IDLE: on a rising edge of `s`, go to HIGH with the counter = 1.
  - HIGH: increment the counter while `s` = 1.
    - Counter > `T_MAX`: pulse `err`, clear bit_cnt and fwd, go to SYNC.
    - Falling edge with counter < `T_MIN`: glitch. Go to LOW with no bit.
    - Falling edge otherwise: bit = (counter ≥ `T_THRESH`). Go to LOW with the counter = 1.
  - LOW: increment the counter (saturating) while `s` = 0.
    - Rising edge: go to HIGH with the counter = 1.
    - Counter reaches `T_RESET`: latch gap, go to IDLE.
- Bit handling, for each decoded bit while fwd = 0:
  - Shift the bit into shreg[23:0], MSB first, and increment bit_cnt (5 bits).
  - When bit_cnt reaches 24: load `color` from shreg, pulse `color_valid`, set fwd = 1, clear bit_cnt.
- Forwarding:
  - fwd = 1 takes effect from the next rising edge of `s`.
  - `dout` = fwd & `s`, registered.
  - Decoded bits are not captured while fwd = 1.
  - A forwarded pulse longer than `T_MAX` still raises `err` and returns the block to SYNC.
- Latch gap:
  - Pulse `frame_done` if bit_cnt ≠ 0 or fwd = 1.
  - If 0 < bit_cnt < 24, the partial word is discarded and `err` pulses in the same cycle as `frame_done`.
  - Clear bit_cnt and fwd. `color` holds its value.
- Reset values:
  - `dout` = 0, `color` = 0, `color_valid` = 0, `frame_done` = 0, `err` = 0.
  - State = SYNC, counter = 0, bit_cnt = 0, fwd = 0, all synchronizer flops = 0.
- Reset asserted mid-frame aborts at once: no `color_valid` and no `frame_done`. After release the block must see a full `T_RESET` low before it accepts bits again.

## Timing
- Pulse width is measured in `s` cycles. Quantization is ±1 cycle.
  - A width equal to `T_THRESH` decodes as 1.
  - A width equal to `T_MAX` is legal; `T_MAX`+1 is an error.
  - A width equal to `T_MIN` is a valid bit.
- `color_valid` latency: it is high during the cycle that starts 3 rising edges after the first edge that samples the 24th falling edge of `din` low.
- `dout` follows `din` with exactly 3 cycles of delay while forwarding. Pulse widths are preserved exactly.
- `frame_done` asserts on the cycle after the low counter reaches `T_RESET`.
- `color_valid` and `frame_done` can never coincide. A bit decode and a latch gap can never share a cycle.

## Test plan
- Reset release, then a 2400-cycle low, then 24 bits encoding 0x12AB34 (0 = 19-cycle high, 1 = 38-cycle high, 60-cycle period), then a gap:
  - `color` = 0x12AB34 with one `color_valid` pulse.
  - `frame_done` pulses once.
  - `dout` stays 0.
- 48 bits (0xFF0000 then 0x00FF00):
  - `color` = 0xFF0000.
  - `dout` reproduces the second 24 pulses at 3-cycle delay with identical widths.
  - One `frame_done`.
- Width boundaries, one frame each:
  - Highs of 28 and 29 cycles decode as 0 and 1.
  - A 4-cycle high is ignored and bit_cnt is unchanged.
  - A 97-cycle high gives an `err` pulse and a return to SYNC; the next frame is accepted only after 2400 low cycles.
- 10 bits then a gap: `err` and `frame_done` pulse together, and `color` is unchanged from the prior value.
- Bits sent immediately after reset, with no prior gap: ignored, with no `color_valid`.
- Reset asserted after 12 bits:
  - All outputs go to 0 on the next edge, with no pulses.
  - The frame after a 2400-cycle gap decodes correctly.
